input_ctrl: RTL

Parametrised front-panel input controller. It synchronises and debounces the board buttons, slide switches and the function-select button, and steps a wrapping function index. It routes the debounced controls onto the instruction slice of the active display function only. It sits between the raw board pins and the VGA function engines, and all of its outputs are registered on sysclk.

---
 rtl/input_ctrl_pkg.sv | 28 ++
 rtl/input_debounce.sv | 61 ++++++
 rtl/input_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/input_ctrl_pkg.sv
// Shared widths, defaults and button bit positions for the front-panel input controller.
package input_ctrl_pkg;

    // Stable cycles required before a level is accepted: 10 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Button bit positions on the 4-button board.
    localparam int BTN_EAST  = 3;
    localparam int BTN_WEST  = 2;
    localparam int BTN_NORTH = 1;
    localparam int BTN_SOUTH = 0;

    // Width of the function index; at least one bit even for a single function.
    function automatic int idx_width(input int num_funcs);
        return (num_funcs > 1) ? $clog2(num_funcs) : 1;
    endfunction

    // Width of one per-function instruction slice: switches above buttons.
    function automatic int instr_width(input int num_sws, input int num_btns);
        return num_sws + num_btns;
    endfunction

    // Debounce counter width, wide enough to hold DEBOUNCE_CYCLES.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/input_debounce.sv
// One raw asynchronous input: 2-flop synchroniser, debounce cell and rising-edge detector.
module input_debounce
    import input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             q;
    logic             q_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser bringing the raw pin into the sysclk domain.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // Accept a new level only after it differs from q for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (sync_out == q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q   <= sync_out;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            q_d <= 1'b0;
        end else begin
            q_d <= q;
        end
    end

    assign level = q;
    assign rise  = q & ~q_d;

endmodule

// File: rtl/input_ctrl.sv
// Front-panel input controller: debounces buttons, switches and the function-select
// button, steps a wrapping function index and routes controls to the active slice.
module input_ctrl
    import input_ctrl_pkg::*;
#(
    parameter int NUM_FUNCS       = 3,
    parameter int NUM_BTNS        = 4,
    parameter int NUM_SWS         = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int INIT_FUNC       = 0,
    localparam int IDX_W          = idx_width(NUM_FUNCS),
    localparam int INSTR_W        = instr_width(NUM_SWS, NUM_BTNS)
) (
    input  logic                         sysclk,
    input  logic                         reset_n,
    input  logic [NUM_BTNS-1:0]          btn_in,
    input  logic [NUM_SWS-1:0]           sw_in,
    input  logic                         change_in,
    output logic [IDX_W-1:0]             func_index,
    output logic                         func_changed,
    output logic [NUM_BTNS-1:0]          btn_level,
    output logic [NUM_BTNS-1:0]          btn_press,
    output logic                         soft_reset,
    output logic [NUM_FUNCS*INSTR_W-1:0] instr
);

    localparam int NUM_IN = NUM_BTNS + NUM_SWS + 1;

    logic [NUM_IN-1:0]            raw_all;
    logic [NUM_IN-1:0]            level_all;
    logic [NUM_IN-1:0]            rise_all;

    logic [NUM_BTNS-1:0]          btn_q;
    logic [NUM_BTNS-1:0]          btn_rise;
    logic [NUM_SWS-1:0]           sw_q;
    logic [NUM_SWS-1:0]           sw_rise_unused;
    logic                         change_level_unused;
    logic                         change_rise;

    logic [IDX_W-1:0]             idx_next;
    logic [NUM_FUNCS*INSTR_W-1:0] instr_next;

    // Change button on top, switches in the middle, buttons at the bottom.
    assign raw_all = {change_in, sw_in, btn_in};

    for (genvar g = 0; g < NUM_IN; g++) begin : g_debounce
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .sysclk (sysclk),
            .reset_n(reset_n),
            .raw    (raw_all[g]),
            .level  (level_all[g]),
            .rise   (rise_all[g])
        );
    end

    assign {change_level_unused, sw_q, btn_q}  = level_all;
    assign {change_rise, sw_rise_unused, btn_rise} = rise_all;

    // Next function index and the instruction bus routed to that index only.
    always_comb begin
        idx_next   = func_index;
        instr_next = '0;
        if (change_rise) begin
            idx_next = (func_index == IDX_W'(NUM_FUNCS - 1)) ? '0 : func_index + IDX_W'(1);
        end
        for (int k = 0; k < NUM_FUNCS; k++) begin
            if (idx_next == IDX_W'(k)) begin
                instr_next[k*INSTR_W +: INSTR_W] = {sw_q, btn_q};
            end
        end
    end

    // Output register: every output updates together on sysclk.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            func_index   <= IDX_W'(INIT_FUNC);
            func_changed <= 1'b0;
            btn_level    <= '0;
            btn_press    <= '0;
            soft_reset   <= 1'b0;
            instr        <= '0;
        end else begin
            func_index   <= idx_next;
            func_changed <= change_rise;
            btn_level    <= btn_q;
            btn_press    <= btn_rise;
            soft_reset   <= sw_q[0];
            instr        <= instr_next;
        end
    end

endmodule
